// File: rtl/param_xmit_if.sv
// Handshake and serial-line bundle for param_xmit: the requester drives start,
// the transmitter drives the serial line plus its busy/done status.
interface param_xmit_if;
  logic start;
  logic data;
  logic busy;
  logic done;

  modport master (
    output start,
    input  data,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    output data,
    output busy,
    output done
  );
endinterface

// File: rtl/param_xmit.sv
// Serial transmitter of the elaboration-time constant FOO: start bit, WIDTH data bits
// LSB first, optional even-parity bit (macro PARAM_XMIT_PARITY_EN), stop bit.
module param_xmit #(
  parameter int FOO        = 1,
  parameter int WIDTH      = 32,
  parameter int BIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  param_xmit_if.slave   bus
);

  localparam int                IDX_W      = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]  PAYLOAD    = WIDTH'(FOO);
  localparam logic [15:0]       CYC_RELOAD = 16'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WIDTH - 1);
`ifdef PARAM_XMIT_PARITY_EN
  localparam logic              PARITY_BIT = ^PAYLOAD;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARAM_XMIT_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic [15:0]      cyc;
  logic [IDX_W-1:0] idx;
  logic             bit_end;
  logic             next_bit;

  // next_bit is payload bit idx+1, selected by mask so no index narrower than idx is needed
  always_comb begin
    bit_end  = (cyc == '0);
    next_bit = |(PAYLOAD & (WIDTH'(1) << (idx + 1'b1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cyc      <= '0;
      idx      <= '0;
      bus.data <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= START;
            cyc      <= CYC_RELOAD;
            bus.data <= 1'b0;
            bus.busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            cyc      <= CYC_RELOAD;
            idx      <= '0;
            bus.data <= PAYLOAD[0];
          end else begin
            cyc <= cyc - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc <= CYC_RELOAD;
            if (idx == LAST_IDX) begin
`ifdef PARAM_XMIT_PARITY_EN
              state    <= PARITY;
              bus.data <= PARITY_BIT;
`else
              state    <= STOP;
              bus.data <= 1'b1;
              bus.done <= (BIT_CYCLES == 1);
`endif
            end else begin
              idx      <= idx + 1'b1;
              bus.data <= next_bit;
            end
          end else begin
            cyc <= cyc - 1'b1;
          end
        end
`ifdef PARAM_XMIT_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            cyc      <= CYC_RELOAD;
            bus.data <= 1'b1;
            bus.done <= (BIT_CYCLES == 1);
          end else begin
            cyc <= cyc - 1'b1;
          end
        end
`endif
        STOP: begin
          // done is registered, so it is raised one cycle ahead of the final STOP cycle
          if (bit_end) begin
            state    <= IDLE;
            idx      <= '0;
            bus.data <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            cyc      <= cyc - 1'b1;
            bus.done <= (cyc == 16'd1);
          end
        end
        default: begin
          state    <= IDLE;
          cyc      <= '0;
          idx      <= '0;
          bus.data <= 1'b1;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_xmit.sv
// Directed bench for param_xmit with three parameterisations; expected frames are
// hand-computed for both builds of PARAM_XMIT_PARITY_EN.
module tb_param_xmit;

  // Expected line values per bit slot, slot 0 first (start bit)
`ifdef PARAM_XMIT_PARITY_EN
  localparam logic [31:0] EXP_A = 32'h0000_040A;  // 0,1,0,1,0,0,0,0,0,0,1
  localparam int          NB_A  = 11;
  localparam logic [31:0] EXP_B = 32'h0000_003E;  // 0,1,1,1,1,1
  localparam int          NB_B  = 6;
  localparam logic [31:0] EXP_C = 32'h0000_000E;  // 0,1,1,1
  localparam int          NB_C  = 4;
`else
  localparam logic [31:0] EXP_A = 32'h0000_020A;  // 0,1,0,1,0,0,0,0,0,1
  localparam int          NB_A  = 10;
  localparam logic [31:0] EXP_B = 32'h0000_001E;  // 0,1,1,1,1
  localparam int          NB_B  = 5;
  localparam logic [31:0] EXP_C = 32'h0000_0006;  // 0,1,1
  localparam int          NB_C  = 3;
`endif
  localparam int BC_A  = 2;
  localparam int CYC_A = NB_A * BC_A;
  localparam int CYC_B = NB_B;
  localparam int CYC_C = NB_C;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  param_xmit_if if_a();
  param_xmit_if if_b();
  param_xmit_if if_c();

  param_xmit #(.FOO(5), .WIDTH(8), .BIT_CYCLES(2)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  param_xmit #(.FOO(7), .WIDTH(3), .BIT_CYCLES(1)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  param_xmit #(.FOO(1), .WIDTH(1), .BIT_CYCLES(1)) u_c (.clk(clk), .reset(reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if_a.start = 1'b1;
    if_b.start = 1'b1;
    if_c.start = 1'b1;
    tick();
    tick();
    checks += 9;
    if (if_a.data !== 1'b1) begin errors++; $display("FAIL reset_a_data got=%b exp=1", if_a.data); end
    if (if_a.busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got=%b exp=0", if_a.busy); end
    if (if_a.done !== 1'b0) begin errors++; $display("FAIL reset_a_done got=%b exp=0", if_a.done); end
    if (if_b.data !== 1'b1) begin errors++; $display("FAIL reset_b_data got=%b exp=1", if_b.data); end
    if (if_b.busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy got=%b exp=0", if_b.busy); end
    if (if_b.done !== 1'b0) begin errors++; $display("FAIL reset_b_done got=%b exp=0", if_b.done); end
    if (if_c.data !== 1'b1) begin errors++; $display("FAIL reset_c_data got=%b exp=1", if_c.data); end
    if (if_c.busy !== 1'b0) begin errors++; $display("FAIL reset_c_busy got=%b exp=0", if_c.busy); end
    if (if_c.done !== 1'b0) begin errors++; $display("FAIL reset_c_done got=%b exp=0", if_c.done); end
    reset = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    tick();
    tick();
    checks++;
    if (if_a.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset_busy got=%b exp=0", if_a.busy); end
  endtask

  task automatic test_frame_a;
    logic [31:0] exp;
    exp = EXP_A;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int c = 1; c <= CYC_A; c++) begin
      checks += 3;
      if (if_a.data !== exp[(c-1)/BC_A]) begin errors++; $display("FAIL frame_a_data cyc=%0d got=%b exp=%b", c, if_a.data, exp[(c-1)/BC_A]); end
      if (if_a.busy !== 1'b1) begin errors++; $display("FAIL frame_a_busy cyc=%0d got=%b exp=1", c, if_a.busy); end
      if (if_a.done !== (c == CYC_A)) begin errors++; $display("FAIL frame_a_done cyc=%0d got=%b exp=%b", c, if_a.done, (c == CYC_A)); end
      tick();
    end
    checks += 3;
    if (if_a.busy !== 1'b0) begin errors++; $display("FAIL frame_a_end_busy got=%b exp=0", if_a.busy); end
    if (if_a.data !== 1'b1) begin errors++; $display("FAIL frame_a_end_data got=%b exp=1", if_a.data); end
    if (if_a.done !== 1'b0) begin errors++; $display("FAIL frame_a_end_done got=%b exp=0", if_a.done); end
  endtask

  task automatic test_frame_b;
    logic [31:0] exp;
    exp = EXP_B;
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    for (int c = 1; c <= CYC_B; c++) begin
      checks += 3;
      if (if_b.data !== exp[c-1]) begin errors++; $display("FAIL frame_b_data cyc=%0d got=%b exp=%b", c, if_b.data, exp[c-1]); end
      if (if_b.busy !== 1'b1) begin errors++; $display("FAIL frame_b_busy cyc=%0d got=%b exp=1", c, if_b.busy); end
      if (if_b.done !== (c == CYC_B)) begin errors++; $display("FAIL frame_b_done cyc=%0d got=%b exp=%b", c, if_b.done, (c == CYC_B)); end
      tick();
    end
    checks += 2;
    if (if_b.busy !== 1'b0) begin errors++; $display("FAIL frame_b_end_busy got=%b exp=0", if_b.busy); end
    if (if_b.done !== 1'b0) begin errors++; $display("FAIL frame_b_end_done got=%b exp=0", if_b.done); end
  endtask

  task automatic test_start_ignored;
    logic [31:0] exp;
    int dones;
    exp = EXP_A;
    dones = 0;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int c = 1; c <= CYC_A; c++) begin
      checks += 2;
      if (if_a.data !== exp[(c-1)/BC_A]) begin errors++; $display("FAIL ignore_data cyc=%0d got=%b exp=%b", c, if_a.data, exp[(c-1)/BC_A]); end
      if (if_a.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy cyc=%0d got=%b exp=1", c, if_a.busy); end
      if (if_a.done === 1'b1) dones++;
      if (c == 6 || c == CYC_A) if_a.start = 1'b1;
      else if_a.start = 1'b0;
      tick();
    end
    if_a.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (if_a.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy k=%0d got=%b exp=0", k, if_a.busy); end
      if (if_a.data !== 1'b1) begin errors++; $display("FAIL ignore_idle_data k=%0d got=%b exp=1", k, if_a.data); end
      if (if_a.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp;
    exp = EXP_A;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      checks += 2;
      if (if_a.data !== exp[(c-1)/BC_A]) begin errors++; $display("FAIL abort_data cyc=%0d got=%b exp=%b", c, if_a.data, exp[(c-1)/BC_A]); end
      if (if_a.done !== 1'b0) begin errors++; $display("FAIL abort_done cyc=%0d got=%b exp=0", c, if_a.done); end
      if (c == 7) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    checks += 3;
    if (if_a.data !== 1'b1) begin errors++; $display("FAIL abort_after_data got=%b exp=1", if_a.data); end
    if (if_a.busy !== 1'b0) begin errors++; $display("FAIL abort_after_busy got=%b exp=0", if_a.busy); end
    if (if_a.done !== 1'b0) begin errors++; $display("FAIL abort_after_done got=%b exp=0", if_a.done); end
    tick();
    checks += 2;
    if (if_a.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got=%b exp=0", if_a.busy); end
    if (if_a.done !== 1'b0) begin errors++; $display("FAIL abort_idle_done got=%b exp=0", if_a.done); end
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int c = 1; c <= CYC_A; c++) begin
      checks += 3;
      if (if_a.data !== exp[(c-1)/BC_A]) begin errors++; $display("FAIL refr_data cyc=%0d got=%b exp=%b", c, if_a.data, exp[(c-1)/BC_A]); end
      if (if_a.busy !== 1'b1) begin errors++; $display("FAIL refr_busy cyc=%0d got=%b exp=1", c, if_a.busy); end
      if (if_a.done !== (c == CYC_A)) begin errors++; $display("FAIL refr_done cyc=%0d got=%b exp=%b", c, if_a.done, (c == CYC_A)); end
      tick();
    end
    checks++;
    if (if_a.busy !== 1'b0) begin errors++; $display("FAIL refr_end_busy got=%b exp=0", if_a.busy); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    int dones;
    exp = EXP_C;
    dones = 0;
    if_c.start = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int c = 1; c <= CYC_C; c++) begin
        checks += 3;
        if (if_c.data !== exp[c-1]) begin errors++; $display("FAIL b2b_data frame=%0d cyc=%0d got=%b exp=%b", f, c, if_c.data, exp[c-1]); end
        if (if_c.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy frame=%0d cyc=%0d got=%b exp=1", f, c, if_c.busy); end
        if (if_c.done !== (c == CYC_C)) begin errors++; $display("FAIL b2b_done frame=%0d cyc=%0d got=%b exp=%b", f, c, if_c.done, (c == CYC_C)); end
        if (if_c.done === 1'b1) dones++;
        tick();
      end
      checks += 3;
      if (if_c.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy frame=%0d got=%b exp=0", f, if_c.busy); end
      if (if_c.data !== 1'b1) begin errors++; $display("FAIL b2b_gap_data frame=%0d got=%b exp=1", f, if_c.data); end
      if (if_c.done !== 1'b0) begin errors++; $display("FAIL b2b_gap_done frame=%0d got=%b exp=0", f, if_c.done); end
      if (f == 2) if_c.start = 1'b0;
      tick();
    end
    checks += 2;
    if (if_c.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop_busy got=%b exp=0", if_c.busy); end
    if (dones !== 3) begin errors++; $display("FAIL b2b_done_count got=%0d exp=3", dones); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    test_reset();
    test_frame_a();
    test_frame_b();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
